imem_load_arb: RTL and testbench

Arbiter and loader sequencer for the single-ported instruction memory of the single-cycle MIPS core. In normal operation it passes CPU fetches straight through to the instruction memory. On request, it stalls the CPU, receives a program image as a byte stream from the UART receiver, and writes it word-by-word into the memory. When loading finishes it releases the CPU, which refetches at whatever PC it holds.

---
 rtl/imem_load_arb.sv | 169 ++++++++++++++++
 tb/tb_imem_load_arb.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_load_arb.sv
// Instruction memory arbiter: CPU fetch pass-through plus UART program loader.
// Define IMEM_LOAD_CSUM_EN to expect a trailing XOR checksum byte per load.
module imem_load_arb #(
   parameter int ROM_SIZE = 256,
   parameter int ADDR_W   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       cpu_addr,
   output logic [31:0]       cpu_data,
   output logic              cpu_stall,
   input  logic              load_req,
   input  logic [7:0]        ld_data,
   input  logic              ld_valid,
   output logic              ld_ready,
   output logic              load_busy,
   output logic              load_done,
   output logic              load_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_we,
   input  logic [31:0]       mem_rdata
);

`ifdef IMEM_LOAD_CSUM_EN
   typedef enum logic [2:0] {RUN, HDR0, HDR1, WORD, WRITE, CSUM, DONE} state_t;
`else
   typedef enum logic [2:0] {RUN, HDR0, HDR1, WORD, WRITE, DONE} state_t;
`endif

   localparam logic [31:0] ROM_SZ = 32'(ROM_SIZE);

   state_t            state;
   logic [7:0]        n_lo;
   logic [15:0]       n_words;
   logic [15:0]       cnt;
   logic [ADDR_W-1:0] wr_addr;
   logic [1:0]        bcnt;
   logic              busy;
   logic [15:0]       hdr_n;
   logic              in_rom;
   logic              unused_ok;
`ifdef IMEM_LOAD_CSUM_EN
   logic [7:0]        csum;
`endif

   assign hdr_n     = {ld_data, n_lo};
   assign in_rom    = {3'b000, cpu_addr[30:2]} < ROM_SZ;
   assign unused_ok = ^{cpu_addr[31], cpu_addr[1:0]};

   // Memory port belongs to the CPU only while running.
   assign mem_addr  = (state == RUN) ? cpu_addr[ADDR_W+1:2] : wr_addr;
   assign cpu_data  = (state == RUN && in_rom) ? mem_rdata : 32'h0;
   assign cpu_stall = busy;
   assign load_busy = busy;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= RUN;
         busy      <= 1'b0;
         ld_ready  <= 1'b0;
         load_done <= 1'b0;
         load_err  <= 1'b0;
         mem_we    <= 1'b0;
         mem_wdata <= 32'h0;
         n_lo      <= 8'h0;
         n_words   <= 16'h0;
         cnt       <= 16'h0;
         wr_addr   <= '0;
         bcnt      <= 2'd0;
`ifdef IMEM_LOAD_CSUM_EN
         csum      <= 8'h0;
`endif
      end else begin
         load_done <= 1'b0;
         mem_we    <= 1'b0;
         unique case (state)
            RUN: begin
               if (load_req) begin
                  state    <= HDR0;
                  busy     <= 1'b1;
                  ld_ready <= 1'b1;
                  load_err <= 1'b0;
                  cnt      <= 16'h0;
                  wr_addr  <= '0;
                  bcnt     <= 2'd0;
`ifdef IMEM_LOAD_CSUM_EN
                  csum     <= 8'h0;
`endif
               end
            end
            HDR0: begin
               if (ld_valid) begin
                  n_lo  <= ld_data;
                  state <= HDR1;
               end
            end
            HDR1: begin
               if (ld_valid) begin
                  n_words <= hdr_n;
                  if (hdr_n == 16'h0) begin
                     state     <= DONE;
                     ld_ready  <= 1'b0;
                     load_done <= 1'b1;
                  end else if ({16'h0, hdr_n} > ROM_SZ) begin
                     state     <= DONE;
                     ld_ready  <= 1'b0;
                     load_done <= 1'b1;
                     load_err  <= 1'b1;
                  end else begin
                     state <= WORD;
                  end
               end
            end
            WORD: begin
               if (ld_valid) begin
                  // Shift right so the first byte lands in [7:0].
                  mem_wdata <= {ld_data, mem_wdata[31:8]};
                  bcnt      <= bcnt + 2'd1;
`ifdef IMEM_LOAD_CSUM_EN
                  csum      <= csum ^ ld_data;
`endif
                  if (bcnt == 2'd3) begin
                     state    <= WRITE;
                     ld_ready <= 1'b0;
                     mem_we   <= 1'b1;
                  end
               end
            end
            WRITE: begin
               wr_addr <= wr_addr + ADDR_W'(1);
               cnt     <= cnt + 16'd1;
               if (cnt + 16'd1 == n_words) begin
`ifdef IMEM_LOAD_CSUM_EN
                  state    <= CSUM;
                  ld_ready <= 1'b1;
`else
                  state     <= DONE;
                  load_done <= 1'b1;
`endif
               end else begin
                  state    <= WORD;
                  ld_ready <= 1'b1;
               end
            end
`ifdef IMEM_LOAD_CSUM_EN
            CSUM: begin
               if (ld_valid) begin
                  if (ld_data != csum) load_err <= 1'b1;
                  state     <= DONE;
                  ld_ready  <= 1'b0;
                  load_done <= 1'b1;
               end
            end
`endif
            DONE: begin
               state <= RUN;
               busy  <= 1'b0;
            end
            default: begin
               state    <= RUN;
               busy     <= 1'b0;
               ld_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_load_arb.sv
// Bench for imem_load_arb: bench-side memory, write scoreboard and directed loads.
// Build with IMEM_LOAD_CSUM_EN to exercise the checksum byte.
module tb_imem_load_arb;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_data;
   logic        cpu_stall;
   logic        load_req;
   logic [7:0]  ld_data;
   logic        ld_valid;
   logic        ld_ready;
   logic        load_busy;
   logic        load_done;
   logic        load_err;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic [31:0] mem_rdata;

   imem_load_arb #(.ROM_SIZE(256), .ADDR_W(8)) dut (
      .clk(clk), .reset(reset),
      .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_stall(cpu_stall),
      .load_req(load_req), .ld_data(ld_data), .ld_valid(ld_valid),
      .ld_ready(ld_ready), .load_busy(load_busy), .load_done(load_done),
      .load_err(load_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   logic [31:0] tbmem [0:255];
   logic        mem_init;
   logic        checking;
   logic [39:0] wq [$];
   logic [31:0] words [$];
   int total = 0;
   int bad = 0;
   int stall_cyc = 0;
   int done_cnt = 0;

   assign mem_rdata = tbmem[mem_addr];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++)
            tbmem[i] <= (i == 3) ? 32'h3c084000 : (32'hA5000000 | 32'(i));
      end else if (mem_we) begin
         tbmem[mem_addr] <= mem_wdata;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Every-cycle check against the bench memory and the write scoreboard.
   always @(negedge clk) begin
      logic [31:0] e;
      logic [39:0] w;
      if (checking) begin
         if (cpu_stall) stall_cyc++;
         if (load_done) done_cnt++;
         if (cpu_stall || cpu_addr[30:2] >= 29'd256) e = 32'h0;
         else e = tbmem[cpu_addr[9:2]];
         chk("cpu_data", cpu_data, e);
         chk("busy_vs_stall", {31'h0, load_busy}, {31'h0, cpu_stall});
         if (mem_we) begin
            chk("we_while_run", {31'h0, cpu_stall}, 32'h1);
            chk("we_with_ready", {31'h0, ld_ready}, 32'h0);
            if (wq.size() == 0) begin
               chk("unexpected_write", 32'h1, 32'h0);
            end else begin
               w = wq.pop_front();
               chk("write_addr", {24'h0, mem_addr}, {24'h0, w[39:32]});
               chk("write_data", mem_wdata, w[31:0]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_req();
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      ld_data  = b;
      ld_valid = 1'b1;
      @(negedge clk);
      while (!ld_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!ld_ready) chk("ld_ready_timeout", 32'h0, 32'h1);
      @(posedge clk);
      #1;
      ld_valid = 1'b0;
   endtask

   // Full load of `words`; starts and ends just after a rising edge.
   task automatic run_load(input string nm, input int n,
                           input logic [7:0] cs, input logic exp_err);
      int d0 = done_cnt;
      int k = 0;
      int expc;
      logic [15:0] n16 = 16'(n);
      stall_cyc = 0;
      pulse_req();
      send_byte(n16[7:0]);
      send_byte(n16[15:8]);
      if (n > 0 && n <= 256) begin
         for (int i = 0; i < n; i++) begin
            logic [31:0] wd = words[i];
            wq.push_back({8'(i), wd});
            for (int j = 0; j < 4; j++) send_byte(wd[8*j +: 8]);
         end
`ifdef IMEM_LOAD_CSUM_EN
         send_byte(cs);
`endif
      end
      while (!load_done && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk({nm, "_done_seen"}, {31'h0, load_done}, 32'h1);
      chk({nm, "_err"}, {31'h0, load_err}, {31'h0, exp_err});
      tick();
      @(negedge clk);
      chk({nm, "_stall_drop"}, {31'h0, cpu_stall}, 32'h0);
      chk({nm, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
      chk({nm, "_err_hold"}, {31'h0, load_err}, {31'h0, exp_err});
      expc = (n == 0 || n > 256) ? 3 : 3 + 5 * n;
`ifdef IMEM_LOAD_CSUM_EN
      if (n > 0 && n <= 256) expc++;
`endif
      chk({nm, "_stall_cycles"}, 32'(stall_cyc), 32'(expc));
      chk({nm, "_writes_left"}, 32'(wq.size()), 32'd0);
      tick();
   endtask

   initial begin
      reset    = 1'b1;
      mem_init = 1'b1;
      checking = 1'b0;
      cpu_addr = 32'h0;
      load_req = 1'b0;
      ld_data  = 8'h0;
      ld_valid = 1'b0;
      repeat (2) tick();
      mem_init = 1'b0;
      @(negedge clk);
      chk("rst_stall", {31'h0, cpu_stall}, 32'h0);
      chk("rst_ready", {31'h0, ld_ready}, 32'h0);
      chk("rst_busy", {31'h0, load_busy}, 32'h0);
      chk("rst_done", {31'h0, load_done}, 32'h0);
      chk("rst_err", {31'h0, load_err}, 32'h0);
      chk("rst_we", {31'h0, mem_we}, 32'h0);
      chk("rst_wdata", mem_wdata, 32'h0);
      tick();
      reset    = 1'b0;
      checking = 1'b1;

      cpu_addr = 32'h0000000C;
      @(negedge clk);
      chk("fetch_c_data", cpu_data, 32'h3c084000);
      chk("fetch_c_addr", {24'h0, mem_addr}, 32'd3);
      chk("fetch_c_stall", {31'h0, cpu_stall}, 32'h0);
      cpu_addr = 32'h00000400;
      @(negedge clk);
      chk("fetch_oob", cpu_data, 32'h0);
      cpu_addr = 32'h000003FC;
      @(negedge clk);
      chk("fetch_last", cpu_data, 32'hA50000FF);
      cpu_addr = 32'h0;
      tick();

      words = '{32'h08000003, 32'h08000029};
      run_load("two_words", 2, 8'h2A, 1'b0);
      cpu_addr = 32'h4;
      @(negedge clk);
      chk("fetch_w1", cpu_data, 32'h08000029);
      cpu_addr = 32'h0;
      @(negedge clk);
      chk("fetch_w0", cpu_data, 32'h08000003);
      tick();

      run_load("oversize", 257, 8'h00, 1'b1);

      pulse_req();
      @(negedge clk);
      chk("req_clears_err", {31'h0, load_err}, 32'h0);
      chk("req_stall", {31'h0, cpu_stall}, 32'h1);
      tick();
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'hAA);
      send_byte(8'hBB);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_stall", {31'h0, cpu_stall}, 32'h0);
      chk("midrst_ready", {31'h0, ld_ready}, 32'h0);
      chk("midrst_wdata", mem_wdata, 32'h0);
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_run_stall", {31'h0, cpu_stall}, 32'h0);
      chk("midrst_keep_w0", cpu_data, 32'h08000003);
      chk("midrst_no_write", 32'(wq.size()), 32'd0);
      tick();

      run_load("empty", 0, 8'h00, 1'b0);

      words = '{32'h08000003};
      run_load("csum_good", 1, 8'h0B, 1'b0);
`ifdef IMEM_LOAD_CSUM_EN
      run_load("csum_bad", 1, 8'h00, 1'b1);
`endif
      @(negedge clk);
      chk("final_w0", cpu_data, 32'h08000003);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
